// File: rtl/arv_pkg.sv
// Core-wide widths plus the read arbiter's state and requester encodings.
// Shared by the memory read interface, the arbiter and its grant sub-block.
package arv_pkg;

  localparam int XLEN          = 32;
  localparam int PHY_ADDR_SIZE = 32;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_e;
  typedef enum logic {REQ_IFETCH, REQ_DMEM} req_id_e;

endpackage

// File: rtl/memory_read_if.sv
// Single-beat read port: requester holds rd_en until rd_valid; responder returns data.
// REQ is the issuing side, RESP the answering side.
interface memory_read_if;

  logic                              rd_en;
  logic [arv_pkg::PHY_ADDR_SIZE-1:0] rd_addr;
  logic                              rd_valid;
  logic [arv_pkg::XLEN-1:0]          rd_data;

  modport REQ  (output rd_en, rd_addr, input  rd_valid, rd_data);
  modport RESP (input  rd_en, rd_addr, output rd_valid, rd_data);

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way grant (ifetch vs dmem): combinational pick, last_grant updates on grant_take.
// Zero latency; loser simply keeps requesting, no backpressure of its own.
module rr_arbiter2
  import arv_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    req_ifetch,
  input  logic    req_dmem,
  input  logic    grant_take,
  output req_id_e gnt_id
);

  req_id_e last_grant_q, last_grant_d;

  always_comb begin
    gnt_id = REQ_IFETCH;
    if (req_ifetch && req_dmem) begin
      if (ROUND_ROBIN != 0) begin
        gnt_id = (last_grant_q == REQ_DMEM) ? REQ_IFETCH : REQ_DMEM;
      end else begin
        gnt_id = REQ_DMEM;
      end
    end else if (req_dmem) begin
      gnt_id = REQ_DMEM;
    end
    last_grant_d = grant_take ? gnt_id : last_grant_q;
  end

  // Reset to dmem so the first contended grant favours ifetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= REQ_DMEM;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/memory_read_arbiter.sv
// Serialises ifetch/dmem reads onto one memory port, one outstanding; routes responses back.
// rd_en->mem.rd_en 1 cycle, response path 0 cycles; requesters are held off by their rd_en-until-rd_valid handshake.
module memory_read_arbiter
  import arv_pkg::*;
#(
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  memory_read_if.RESP      ifetch,
  memory_read_if.RESP      dmem,
  memory_read_if.REQ       mem,
  output logic             busy,
  output logic             grant_id,
  output logic             err_timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_e               state_q, state_d;
  req_id_e                  gid_q, gid_d;
  logic [PHY_ADDR_SIZE-1:0] addr_q, addr_d;
  logic                     mem_en_q, mem_en_d;
  logic                     busy_q, busy_d;
  logic                     err_q, err_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  req_id_e                  arb_gnt;
  logic                     grant_take;
  logic                     done;
  logic [XLEN-1:0]          rdata;

  rr_arbiter2 #(.ROUND_ROBIN(ROUND_ROBIN)) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_ifetch (ifetch.rd_en),
    .req_dmem   (dmem.rd_en),
    .grant_take (grant_take),
    .gnt_id     (arb_gnt)
  );

  // err_q is raised one cycle ahead so the forced completion lands on count == TIMEOUT_CYCLES.
  assign done = (state_q == ARB_WAIT) && (mem.rd_valid || err_q);

  always_comb begin
    state_d    = state_q;
    gid_d      = gid_q;
    addr_d     = addr_q;
    mem_en_d   = 1'b0;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    grant_take = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (ifetch.rd_en || dmem.rd_en) begin
          grant_take = 1'b1;
          gid_d      = arb_gnt;
          addr_d     = (arb_gnt == REQ_DMEM) ? dmem.rd_addr : ifetch.rd_addr;
          mem_en_d   = 1'b1;
          state_d    = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        cnt_d   = '0;
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (done) begin
          state_d = ARB_IDLE;
        end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST)) begin
          err_d = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      gid_q    <= REQ_IFETCH;
      addr_q   <= '0;
      mem_en_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gid_q    <= gid_d;
      addr_q   <= addr_d;
      mem_en_q <= mem_en_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    rdata           = err_q ? '0 : mem.rd_data;
    ifetch.rd_valid = done && (gid_q == REQ_IFETCH);
    dmem.rd_valid   = done && (gid_q == REQ_DMEM);
    ifetch.rd_data  = ifetch.rd_valid ? rdata : '0;
    dmem.rd_data    = dmem.rd_valid ? rdata : '0;
  end

  assign mem.rd_en   = mem_en_q;
  assign mem.rd_addr = addr_q;
  assign busy        = busy_q;
  assign grant_id    = gid_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_memory_read_arbiter.sv
// Directed bench: dut_a (round robin, timeout 4) and dut_b (fixed priority) with simple memory responders.
module tb_memory_read_arbiter;
  import arv_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  memory_read_if ia();
  memory_read_if da();
  memory_read_if ma();
  memory_read_if ib();
  memory_read_if db();
  memory_read_if mb();

  logic busy_a, gid_a, err_a, busy_b, gid_b, err_b;

  logic        resp_vld_a = 1'b0, spur_vld_a = 1'b0, resp_vld_b = 1'b0;
  logic [31:0] resp_dat_a = '0, spur_dat_a = '0, resp_dat_b = '0;
  bit          mute_a = 1'b0;
  int          lat_a  = 3;
  int          lat_b  = 1;

  assign ma.rd_valid = resp_vld_a | spur_vld_a;
  assign ma.rd_data  = spur_vld_a ? spur_dat_a : resp_dat_a;
  assign mb.rd_valid = resp_vld_b;
  assign mb.rd_data  = resp_dat_b;

  memory_read_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .ifetch(ia), .dmem(da), .mem(ma),
    .busy(busy_a), .grant_id(gid_a), .err_timeout(err_a)
  );

  memory_read_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .ifetch(ib), .dmem(db), .mem(mb),
    .busy(busy_b), .grant_id(gid_b), .err_timeout(err_b)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {16'hC0DE, a[15:0]};
  endfunction

  initial begin : responder_a
    logic [31:0] a;
    forever begin
      @(posedge clk); #1;
      resp_vld_a = 1'b0;
      resp_dat_a = '0;
      if (ma.rd_en === 1'b1 && !mute_a) begin
        a = ma.rd_addr;
        repeat (lat_a) begin @(posedge clk); #1; end
        resp_vld_a = 1'b1;
        resp_dat_a = mem_val(a);
      end
    end
  end

  initial begin : responder_b
    logic [31:0] a;
    forever begin
      @(posedge clk); #1;
      resp_vld_b = 1'b0;
      resp_dat_b = '0;
      if (mb.rd_en === 1'b1) begin
        a = mb.rd_addr;
        repeat (lat_b) begin @(posedge clk); #1; end
        resp_vld_b = 1'b1;
        resp_dat_b = mem_val(a);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Waits (bounded) for the next requester rd_valid; who = 0 ifetch, 1 dmem, 2 both, -1 none.
  task automatic wait_vld(input bit sel, output int who, output logic [31:0] dat, output int at);
    logic v0, v1;
    bit   seen;
    who  = -1;
    dat  = '0;
    at   = -1;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      tick();
      v0 = sel ? ib.rd_valid : ia.rd_valid;
      v1 = sel ? db.rd_valid : da.rd_valid;
      if (v0 || v1) begin
        seen = 1'b1;
        who  = (v0 && v1) ? 2 : (v0 ? 0 : 1);
        dat  = v0 ? (sel ? ib.rd_data : ia.rd_data) : (sel ? db.rd_data : da.rd_data);
        at   = cyc;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_cmp++; if ({ma.rd_en, busy_a, gid_a, err_a, ia.rd_valid, da.rd_valid} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 000000", {ma.rd_en, busy_a, gid_a, err_a, ia.rd_valid, da.rd_valid}); end
    n_cmp++; if (ma.rd_addr !== 32'h0) begin
      n_bad++; $display("FAIL reset_addr: got %h want 00000000", ma.rd_addr); end
    n_cmp++; if ({ia.rd_data, da.rd_data} !== 64'h0) begin
      n_bad++; $display("FAIL reset_rdata: got %h want 0", {ia.rd_data, da.rd_data}); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    ia.rd_en = 1'b1; ia.rd_addr = 32'h100;
    tick();
    n_cmp++; if ({ma.rd_en, busy_a, gid_a} !== 3'b110) begin
      n_bad++; $display("FAIL single_issue: got %b want 110", {ma.rd_en, busy_a, gid_a}); end
    n_cmp++; if (ma.rd_addr !== 32'h100) begin
      n_bad++; $display("FAIL single_addr: got %h want 00000100", ma.rd_addr); end
    tick();
    n_cmp++; if ({ma.rd_en, ia.rd_valid} !== 2'b00) begin
      n_bad++; $display("FAIL single_pulse: got %b want 00", {ma.rd_en, ia.rd_valid}); end
    tick();
    n_cmp++; if (ia.rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_early: got %b want 0", ia.rd_valid); end
    tick();
    n_cmp++; if (ia.rd_valid !== 1'b1 || ia.rd_data !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL single_resp: got %b/%h want 1/deadbeef", ia.rd_valid, ia.rd_data); end
    n_cmp++; if (da.rd_valid !== 1'b0 || da.rd_data !== 32'h0) begin
      n_bad++; $display("FAIL single_other: got %b/%h want 0/0", da.rd_valid, da.rd_data); end
    ia.rd_en = 1'b0;
    tick();
    n_cmp++; if ({busy_a, ia.rd_valid, ma.rd_en} !== 3'b000) begin
      n_bad++; $display("FAIL single_idle: got %b want 000", {busy_a, ia.rd_valid, ma.rd_en}); end
  endtask

  task automatic test_round_robin();
    int          exp_who[4] = '{0, 1, 0, 1};
    int          who, at;
    logic [31:0] dat;
    do_reset();
    ia.rd_en = 1'b1; ia.rd_addr = 32'h200;
    da.rd_en = 1'b1; da.rd_addr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      wait_vld(1'b0, who, dat, at);
      n_cmp++; if (who !== exp_who[i]) begin
        n_bad++; $display("FAIL rr_grant%0d: got %0d want %0d", i, who, exp_who[i]); end
      n_cmp++; if (dat !== mem_val(exp_who[i] == 0 ? 32'h200 : 32'h300)) begin
        n_bad++; $display("FAIL rr_data%0d: got %h want %h", i, dat, mem_val(exp_who[i] == 0 ? 32'h200 : 32'h300)); end
    end
    ia.rd_en = 1'b0;
    da.rd_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_fixed_priority();
    int          who, at;
    logic [31:0] dat;
    ib.rd_en = 1'b1; ib.rd_addr = 32'h200;
    db.rd_en = 1'b1; db.rd_addr = 32'h300;
    for (int i = 0; i < 3; i++) begin
      wait_vld(1'b1, who, dat, at);
      n_cmp++; if (who !== 1 || dat !== 32'hC0DE0300) begin
        n_bad++; $display("FAIL fp_grant%0d: got %0d/%h want 1/c0de0300", i, who, dat); end
    end
    db.rd_en = 1'b0;
    wait_vld(1'b1, who, dat, at);
    n_cmp++; if (who !== 0 || dat !== 32'hC0DE0200) begin
      n_bad++; $display("FAIL fp_ifetch_after: got %0d/%h want 0/c0de0200", who, dat); end
    ib.rd_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    int          who, at, prev_at;
    logic [31:0] dat;
    prev_at = -1;
    da.rd_en = 1'b1; da.rd_addr = 32'h3F0;
    for (int i = 0; i < 3; i++) begin
      wait_vld(1'b0, who, dat, at);
      n_cmp++; if (who !== 1 || dat !== 32'hC0DE03F0) begin
        n_bad++; $display("FAIL b2b_resp%0d: got %0d/%h want 1/c0de03f0", i, who, dat); end
      if (i > 0) begin
        n_cmp++; if (at - prev_at !== lat_a + 2) begin
          n_bad++; $display("FAIL b2b_period%0d: got %0d want %0d", i, at - prev_at, lat_a + 2); end
      end
      prev_at = at;
    end
    da.rd_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_drop_after_capture();
    int          pulses, issues;
    logic [31:0] dat;
    pulses = 0;
    issues = 0;
    dat    = '0;
    da.rd_en = 1'b1; da.rd_addr = 32'h340;
    tick();
    n_cmp++; if ({ma.rd_en, gid_a} !== 2'b11) begin
      n_bad++; $display("FAIL drop_issue: got %b want 11", {ma.rd_en, gid_a}); end
    da.rd_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (da.rd_valid === 1'b1) begin pulses++; dat = da.rd_data; end
      if (ma.rd_en === 1'b1) issues++;
    end
    n_cmp++; if (pulses !== 1 || dat !== 32'hC0DE0340) begin
      n_bad++; $display("FAIL drop_resp: got %0d pulses/%h want 1/c0de0340", pulses, dat); end
    n_cmp++; if (issues !== 0) begin
      n_bad++; $display("FAIL drop_reissue: got %0d want 0", issues); end
  endtask

  task automatic test_timeout();
    int early;
    early  = 0;
    mute_a = 1'b1;
    ia.rd_en = 1'b1; ia.rd_addr = 32'h180;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      if (ia.rd_valid !== 1'b0 || err_a !== 1'b0) early++;
    end
    n_cmp++; if (early !== 0) begin
      n_bad++; $display("FAIL timeout_early: got %0d cycles want 0", early); end
    tick();
    n_cmp++; if ({ia.rd_valid, err_a} !== 2'b11 || ia.rd_data !== 32'h0) begin
      n_bad++; $display("FAIL timeout_fire: got %b/%h want 11/0", {ia.rd_valid, err_a}, ia.rd_data); end
    ia.rd_en = 1'b0;
    tick();
    n_cmp++; if ({err_a, busy_a, ia.rd_valid} !== 3'b000) begin
      n_bad++; $display("FAIL timeout_idle: got %b want 000", {err_a, busy_a, ia.rd_valid}); end
    mute_a = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    int          who, at;
    logic [31:0] dat;
    mute_a = 1'b1;
    ia.rd_en = 1'b1; ia.rd_addr = 32'h1C0;
    tick();
    tick();
    n_cmp++; if (busy_a !== 1'b1) begin
      n_bad++; $display("FAIL rstw_busy: got %b want 1", busy_a); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({ma.rd_en, busy_a, gid_a, err_a, ia.rd_valid, da.rd_valid} !== 6'b0 || ma.rd_addr !== 32'h0) begin
      n_bad++; $display("FAIL rstw_outputs: got %b/%h want 000000/0", {ma.rd_en, busy_a, gid_a, err_a, ia.rd_valid, da.rd_valid}, ma.rd_addr); end
    ia.rd_en = 1'b0;
    tick();
    rst_n  = 1'b1;
    mute_a = 1'b0;
    ia.rd_en = 1'b1; ia.rd_addr = 32'h200;
    da.rd_en = 1'b1; da.rd_addr = 32'h300;
    tick();
    n_cmp++; if ({ma.rd_en, gid_a} !== 2'b10 || ma.rd_addr !== 32'h200) begin
      n_bad++; $display("FAIL rstw_first_grant: got %b/%h want 10/00000200", {ma.rd_en, gid_a}, ma.rd_addr); end
    wait_vld(1'b0, who, dat, at);
    n_cmp++; if (who !== 0 || dat !== 32'hC0DE0200) begin
      n_bad++; $display("FAIL rstw_first_resp: got %0d/%h want 0/c0de0200", who, dat); end
    ia.rd_en = 1'b0;
    wait_vld(1'b0, who, dat, at);
    n_cmp++; if (who !== 1 || dat !== 32'hC0DE0300) begin
      n_bad++; $display("FAIL rstw_second_resp: got %0d/%h want 1/c0de0300", who, dat); end
    da.rd_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_spurious();
    spur_vld_a = 1'b1;
    spur_dat_a = 32'h12345678;
    #1;
    n_cmp++; if ({ia.rd_valid, da.rd_valid} !== 2'b00 || {ia.rd_data, da.rd_data} !== 64'h0) begin
      n_bad++; $display("FAIL spur_route: got %b/%h want 00/0", {ia.rd_valid, da.rd_valid}, {ia.rd_data, da.rd_data}); end
    tick();
    spur_vld_a = 1'b0;
    spur_dat_a = '0;
    n_cmp++; if ({busy_a, ma.rd_en, err_a} !== 3'b000) begin
      n_bad++; $display("FAIL spur_state: got %b want 000", {busy_a, ma.rd_en, err_a}); end
  endtask

  initial begin
    ia.rd_en = 1'b0; ia.rd_addr = '0;
    da.rd_en = 1'b0; da.rd_addr = '0;
    ib.rd_en = 1'b0; ib.rd_addr = '0;
    db.rd_en = 1'b0; db.rd_addr = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_back_to_back();
    test_drop_after_capture();
    test_timeout();
    test_reset_in_wait();
    test_spurious();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_read_arbiter.md
# memory_read_arbiter

Shares one physical memory read port between the instruction-fetch and data-load requesters of the core. Each requester drives its own `memory_read_if`, and the arbiter serialises their requests onto the single downstream `memory_read_if` with one transaction outstanding. It routes each response back to the requester that issued it and flags responses that never arrive. It sits between the fetch/LSU stages and the memory model or bus bridge.

## Interface
- `ROUND_ROBIN`, default 1: 1 = alternate on contention; 0 = fixed priority, dmem wins.
- `TIMEOUT_CYCLES`, default 0: number of WAIT cycles before a forced error completion; 0 disables the timeout.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ifetch`  `memory_read_if.RESP`  interface  instruction-fetch requester.
- `dmem`  `memory_read_if.RESP`  interface  data-load requester.
- `mem`  `memory_read_if.REQ`  interface  downstream memory port.
- `busy`  out  1  high in ISSUE or WAIT.
- `grant_id`  out  1  requester owning the current transaction (0 = ifetch, 1 = dmem).
- `err_timeout`  out  1  one-cycle pulse on forced completion.

Clock and reset are fixed: one clock `clk`; reset `rst_n` is asynchronous and active-low.

## Operation
**Requester protocol**
- A requester raises `rd_en` with `rd_addr` and holds `rd_en` high until it sees `rd_valid`.
- `rd_en` still high in the cycle after `rd_valid` counts as a new request.

**Memory protocol**
- `mem.rd_en` is a one-cycle pulse.
- `mem.rd_valid` arrives 1 or more cycles later, exactly once per pulse.

**State machine**
- IDLE:
  - If any `rd_en` is high, pick the winner, latch its address and `grant_id`, then go to ISSUE.
  - If no `rd_en` is high, stay in IDLE.
- ISSUE: drive `mem.rd_en`=1 and `mem.rd_addr` = latched address, then go to WAIT.
- WAIT:
  - On `mem.rd_valid`, drive the winner's `rd_valid`=1 and `rd_data` = `mem.rd_data` in the same cycle, then go to IDLE.
  - On timeout, drive the winner's `rd_valid`=1, `rd_data`='0 and `err_timeout`=1, then go to IDLE.

**Arbitration**
- Round robin: a `last_grant` register, reset value ifetch-favoured (`last_grant` = dmem). On contention, grant the requester not equal to `last_grant`. `last_grant` updates on each grant.
- Fixed priority (`ROUND_ROBIN`=0): dmem wins whenever both request.

**Routing and boundary behaviour**
- A non-granted requester sees `rd_valid`=0 and `rd_data`='0.
- A requester that drops `rd_en` after capture still receives its `rd_valid`.
- A requester that drops `rd_en` before capture issues no request.
- `mem.rd_valid` outside WAIT is ignored.
- Timeout counter:
  - Clears on entering WAIT and increments each WAIT cycle.
  - Fires when the count equals `TIMEOUT_CYCLES`.
  - Width is `$clog2(TIMEOUT_CYCLES+1)`, minimum 1.
  - A memory response arriving after a timeout is a system error and is not handled.
- Reset mid-transaction: the FSM returns to IDLE, `last_grant` goes to dmem and the counter clears. An outstanding memory response arriving after reset is ignored only if it arrives outside WAIT.

## Timing
- Reset values of all outputs are 0:
  - `mem.rd_en`, `mem.rd_addr`
  - both requesters' `rd_valid` and `rd_data`
  - `busy`, `grant_id`, `err_timeout`
- `mem.rd_en`, `mem.rd_addr`, `busy`, `grant_id` and `err_timeout` are registered outputs.
- Requester `rd_valid` and `rd_data` are combinational from `mem` plus state, so the return path adds 0 cycles.
- Request latency:
  - Requester `rd_en` sampled at edge N (in IDLE).
  - `mem.rd_en` is high in cycle N+1.
  - Requester `rd_valid` is high in the same cycle as `mem.rd_valid`.
  - The next grant decision is taken at the following edge.
- Back-to-back throughput: one transaction per (memory latency + 2) cycles.

## Structure
- `arv_pkg` gains:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_e`
  - `typedef enum logic {REQ_IFETCH, REQ_DMEM} req_id_e`
- `PHY_ADDR_SIZE` and `XLEN` are reused from `arv_pkg`.
- One sub-module: `rr_arbiter2`, a 2-way grant with the `last_grant` register and the `ROUND_ROBIN` parameter. The FSM, address latch, timeout counter and return mux stay in the top module.

## Test plan
1. Single request: ifetch `rd_en`, addr 0x100; memory returns 0xDEADBEEF 3 cycles after its `rd_en` -> `mem.rd_en` pulses 1 cycle with 0x100; `ifetch.rd_valid` with 0xDEADBEEF; `dmem.rd_valid` stays 0.
2. Simultaneous requests with `ROUND_ROBIN`=1, ifetch 0x200 and dmem 0x300, both held -> grants go ifetch, dmem, ifetch; with `ROUND_ROBIN`=0 dmem is served every time both are requesting.
3. Drop after capture: dmem drops `rd_en` in ISSUE -> its transaction completes and `dmem.rd_valid` still pulses once.
4. Timeout with `TIMEOUT_CYCLES`=4 and memory never responding -> requester `rd_valid` with data 0 and `err_timeout` pulse exactly 4 cycles after entering WAIT; FSM back in IDLE.
5. Async reset asserted in WAIT -> all outputs 0 immediately; the first request after reset is granted to ifetch under contention.
6. Spurious `mem.rd_valid` in IDLE -> no requester `rd_valid`, state unchanged.
